// File: rtl/ram_sp_param.sv
// ram_sp_param
// Parametrised single-port synchronous RAM with byte-enable writes, a 1- or
// 2-stage read pipeline, error strobes for command collisions and
// out-of-range addresses, and an optional zero-fill sequence after reset.
//
// Parameters:
//   DATA_W          data width in bits (multiple of 8)
//   ADDR_W          address width
//   DEPTH           number of words, 1 <= DEPTH <= 2**ADDR_W
//   RD_LAT          read latency in clock edges (1 or 2)
//   CLEAR_ON_RESET  1 = zero every word after reset, 0 = contents undefined
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   cs      in   chip select
//   rd      in   read request
//   wr      in   write request
//   addr    in   word address
//   wdata   in   write data
//   be      in   byte enables, be[i] gates wdata[8i+7:8i]
//   rdata   out  read data, held between reads
//   rvalid  out  one-cycle strobe marking valid rdata
//   busy    out  clear sequence in progress, commands ignored
//   err     out  one-cycle error strobe
module ram_sp_param #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 10,
    parameter int DEPTH          = 1024,
    parameter int RD_LAT         = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs,
    input  logic                rd,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                busy,
    output logic                err
);

    localparam int                LANES     = DATA_W / 8;
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // DEPTH may equal 2**ADDR_W, so the range limit needs one extra bit.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic [ADDR_W-1:0]   w_clr_addr_nxt;
    logic                r_busy;

    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

    logic                w_accept;
    logic                w_oor;
    logic                w_wr_en;
    logic                w_rd_issue;
    logic                w_err_now;
    logic                w_clr_we;
    logic [IDX_W-1:0]    w_idx;
    logic [IDX_W-1:0]    w_clr_idx;
    logic [DATA_W-1:0]   w_rd_word;

    logic                r_s1_valid;
    logic                r_s1_oor;
    logic [DATA_W-1:0]   r_s1_data;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rvalid;
    logic                r_err;

    // Clear FSM state register; reset restarts the clear from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            r_clr_addr <= '0;
            r_busy     <= CLEAR_ON_RESET;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_busy     <= (w_state_nxt == ST_CLEAR);
        end
    end

    // Clear FSM next state: walk the address range once, then go idle.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + ONE_A;
                end
            end
            ST_IDLE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command decode; commands only count while idle and out of reset.
    always_comb begin
        w_accept   = (!rst) && (r_state == ST_IDLE);
        w_clr_we   = (!rst) && (r_state == ST_CLEAR);
        w_oor      = ({1'b0, addr} >= DEPTH_X);
        w_idx      = addr[IDX_W-1:0];
        w_clr_idx  = r_clr_addr[IDX_W-1:0];
        w_wr_en    = w_accept & cs & wr & ~rd & ~w_oor;
        w_rd_issue = w_accept & cs & rd & ~wr;
        // Collision, or a write that falls outside the array.
        w_err_now  = w_accept & cs & wr & (rd | w_oor);
        // Out-of-range reads return zero rather than touching the array.
        if (w_oor) begin
            w_rd_word = '0;
        end else begin
            w_rd_word = r_mem[w_idx];
        end
    end

    // Array write port: the clear sequence and command writes never overlap.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline and error strobe; reset flushes any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_oor   <= 1'b0;
            r_s1_data  <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_issue;
            r_s1_oor   <= w_rd_issue & w_oor;
            if (w_rd_issue) begin
                r_s1_data <= w_rd_word;
            end
            if (RD_LAT == 2) begin
                r_rvalid <= r_s1_valid;
                // A late read-range error may coincide with a fresh collision.
                r_err    <= w_err_now | (r_s1_valid & r_s1_oor);
                if (r_s1_valid) begin
                    r_rdata <= r_s1_data;
                end
            end else begin
                r_rvalid <= w_rd_issue;
                r_err    <= w_err_now | (w_rd_issue & w_oor);
                if (w_rd_issue) begin
                    r_rdata <= w_rd_word;
                end
            end
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign busy   = r_busy;
    assign err    = r_err;

endmodule

// File: tb/tb_ram_sp_param.sv
// Testbench for ram_sp_param. Two instances share one stimulus stream:
//   dut A: DATA_W=32, ADDR_W=10, DEPTH=1000, RD_LAT=2, CLEAR_ON_RESET=1
//   dut B: DATA_W=8,  ADDR_W=5,  DEPTH=16,   RD_LAT=1, CLEAR_ON_RESET=1
// The stimulus process updates a word-array reference model and pushes the
// expected per-edge responses into a scoreboard queue; a monitor pops and
// compares after every rising edge.
module tb_ram_sp_param;

    typedef struct {
        int          due;
        bit          rv;
        bit          er;
        bit          rs;
        logic [31:0] data;
    } exp_t;

    localparam int DEP [2]  = '{1000, 16};
    localparam int LAT [2]  = '{2, 1};
    localparam int LNS [2]  = '{4, 1};
    localparam int AMSK [2] = '{1023, 31};

    logic        clk;
    logic        rst;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;

    logic [31:0] a_rdata;
    logic        a_rvalid;
    logic        a_busy;
    logic        a_err;
    logic [7:0]  b_rdata;
    logic        b_rvalid;
    logic        b_busy;
    logic        b_err;

    exp_t        sb_q [2][$];
    logic [31:0] mem_m [2][1024];
    int          busy_cnt [2];
    logic [31:0] hold [2];
    int          edge_cnt;
    bit          armed;
    int          n_checks;
    int          n_errors;

    ram_sp_param #(.DATA_W(32), .ADDR_W(10), .DEPTH(1000), .RD_LAT(2), .CLEAR_ON_RESET(1'b1)) u_a (
        .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .be(be),
        .rdata(a_rdata), .rvalid(a_rvalid), .busy(a_busy), .err(a_err)
    );

    ram_sp_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(16), .RD_LAT(1), .CLEAR_ON_RESET(1'b1)) u_b (
        .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .addr(addr[4:0]), .wdata(wdata[7:0]), .be(be[0:0]),
        .rdata(b_rdata), .rvalid(b_rvalid), .busy(b_busy), .err(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d edge %0d: got %h expected %h", name, d, edge_cnt, act, exp);
        end
    endtask

    // Reference model: effect of the upcoming edge k on DUT d.
    task automatic model_edge(input int d, input int k);
        exp_t e;
        int   a;
        a = int'(addr) & AMSK[d];
        e.due = k; e.rv = 1'b0; e.er = 1'b0; e.rs = 1'b0; e.data = 32'h0;
        if (rst) begin
            sb_q[d].delete();
            e.rs = 1'b1;
            sb_q[d].push_back(e);
            busy_cnt[d] = DEP[d];
            // Once the clear finishes every word is zero; nothing can be
            // accepted in between.
            for (int i = 0; i < 1024; i++) mem_m[d][i] = 32'h0;
        end else if (busy_cnt[d] > 0) begin
            busy_cnt[d]--;
        end else if (cs) begin
            if (rd && wr) begin
                e.er = 1'b1;
                sb_q[d].push_back(e);
            end else if (wr) begin
                if (a >= DEP[d]) begin
                    e.er = 1'b1;
                    sb_q[d].push_back(e);
                end else begin
                    for (int l = 0; l < LNS[d]; l++)
                        if (be[l]) mem_m[d][a][8*l +: 8] = wdata[8*l +: 8];
                end
            end else if (rd) begin
                e.due  = k + LAT[d] - 1;
                e.rv   = 1'b1;
                e.er   = (a >= DEP[d]);
                e.data = (a >= DEP[d]) ? 32'h0 : mem_m[d][a];
                sb_q[d].push_back(e);
            end
        end
    endtask

    task automatic step(input bit r, input bit c, input bit rr, input bit w,
                        input logic [9:0] a, input logic [31:0] wd, input logic [3:0] b);
        @(negedge clk);
        rst = r; cs = c; rd = rr; wr = w; addr = a; wdata = wd; be = b;
        armed = 1'b1;
        for (int d = 0; d < 2; d++) model_edge(d, edge_cnt + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
    endtask

    task automatic do_wr(input logic [9:0] a, input logic [31:0] wd, input logic [3:0] b);
        step(1'b0, 1'b1, 1'b0, 1'b1, a, wd, b);
    endtask

    task automatic do_rd(input logic [9:0] a);
        step(1'b0, 1'b1, 1'b1, 1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic check_dut(input int d, input logic rv, input logic er, input logic bz, input logic [31:0] rdat);
        exp_t e;
        logic erv;
        logic eer;
        erv = 1'b0;
        eer = 1'b0;
        while (sb_q[d].size() > 0 && sb_q[d][0].due == edge_cnt) begin
            e = sb_q[d].pop_front();
            if (e.rs) hold[d] = 32'h0;
            if (e.rv) begin
                erv = 1'b1;
                hold[d] = e.data;
            end
            if (e.er) eer = 1'b1;
        end
        chk("rvalid", d, {31'd0, rv}, {31'd0, erv});
        chk("err", d, {31'd0, er}, {31'd0, eer});
        chk("busy", d, {31'd0, bz}, {31'd0, (busy_cnt[d] != 0)});
        chk("rdata", d, rdat, hold[d]);
    endtask

    // Monitor: compare both DUTs just after every rising edge.
    initial begin
        edge_cnt = 0;
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            if (armed) begin
                check_dut(0, a_rvalid, a_err, a_busy, a_rdata);
                check_dut(1, b_rvalid, b_err, b_busy, {24'h0, b_rdata});
            end
        end
    end

    initial begin
        int op;
        int guard;
        logic [9:0] ra;
        n_checks = 0;
        n_errors = 0;
        armed = 1'b0;
        hold[0] = 32'h0;
        hold[1] = 32'h0;
        busy_cnt[0] = 0;
        busy_cnt[1] = 0;
        rst = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 10'd0; wdata = 32'h0; be = 4'h0;

        // Reset pulse, a write while busy, then reset again mid-clear.
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        do_wr(10'd3, 32'h0000005A, 4'hF);
        idle(7);
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        idle(20);
        // Dut B is clear by now: read every word (dut A still busy).
        for (int i = 0; i < 16; i++) do_rd(10'(i));
        guard = 0;
        while (busy_cnt[0] != 0 && guard < 2000) begin
            idle(1);
            guard++;
        end
        idle(2);

        // Busy-gated write must not have landed.
        do_rd(10'd3);
        // Byte enables.
        do_wr(10'd5, 32'hAABBCCDD, 4'hF);
        do_wr(10'd5, 32'h11223344, 4'h5);
        do_rd(10'd5);
        idle(2);
        chk("be_merge", 0, a_rdata, 32'hAA22CC44);
        // Pipelined back-to-back reads.
        for (int i = 0; i < 4; i++) do_wr(10'(i), 32'(10 + i), 4'hF);
        for (int i = 0; i < 4; i++) do_rd(10'(i));
        idle(2);
        // Collision at 7, then confirm contents unchanged.
        do_wr(10'd7, 32'h77777777, 4'hF);
        step(1'b0, 1'b1, 1'b1, 1'b1, 10'd7, 32'hDEADBEEF, 4'hF);
        do_rd(10'd7);
        // Out-of-range read and write.
        do_rd(10'd1010);
        do_wr(10'd1010, 32'hCAFEF00D, 4'hF);
        do_rd(10'd1010);
        do_rd(10'd999);
        idle(3);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            op = $urandom_range(0, 9);
            ra = ($urandom_range(0, 9) < 7) ? 10'($urandom_range(0, 31)) : 10'($urandom_range(990, 1023));
            case (op)
                0, 1, 2, 3: do_rd(ra);
                4, 5, 6, 7: do_wr(ra, $urandom, 4'($urandom_range(0, 15)));
                8:          step(1'b0, 1'b1, 1'b1, 1'b1, ra, $urandom, 4'hF);
                default:    step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom, 4'hF);
            endcase
        end

        // Reset one edge after a read is accepted: the read is flushed.
        do_rd(10'd5);
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        idle(3);
        chk("flush_rdata", 0, a_rdata, 32'h0);
        guard = 0;
        while (busy_cnt[0] != 0 && guard < 2000) begin
            idle(1);
            guard++;
        end
        do_rd(10'd5);
        do_rd(10'd5);
        idle(4);
        chk("sb_empty", 0, 32'(sb_q[0].size()), 32'h0);
        chk("sb_empty", 1, 32'(sb_q[1].size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_sp_param.md
# ram_sp_param

Parametrised single-port synchronous RAM and the successor to the fixed 1K×8 RAM. It keeps the cs/rd/wr command style but makes width, depth and read latency configurable. It adds split data buses, byte-enable writes, a read-valid strobe, command-collision and address-range error reporting, and an optional memory-clear sequence after reset. It sits behind bus/controller logic as local scratch or buffer storage.

## Interface
- DATA_W, default 8: data width in bits; multiple of 8.
- ADDR_W, default 10: address width.
- DEPTH, default 1024: number of words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W.
- RD_LAT, default 1: read latency in clock edges; legal values are 1 or 2.
- CLEAR_ON_RESET, default 1: 1 = zero every word after reset; 0 = memory contents are undefined after reset.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cs  in  1  chip select.
- rd  in  1  read request.
- wr  in  1  write request.
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- be  in  DATA_W/8  byte enables; be[i] gates wdata[8i+7:8i].
- rdata  out  DATA_W  read data; holds its value between reads.
- rvalid  out  1  one-cycle strobe marking valid rdata.
- busy  out  1  clear sequence in progress; commands are ignored.
- err  out  1  one-cycle error strobe.

## Operation
Command decode applies on each rising edge with rst=0 and busy=0:
- cs=0, or rd=wr=0: idle.
- **Write**, when cs & wr & !rd:
  - Each byte lane with be[i]=1 is updated with its wdata lane.
  - Lanes with be[i]=0 keep their contents; be=0 performs no write and is not an error.
- **Read**, when cs & rd & !wr: mem[addr] is issued into the read pipeline.
- **Collision**, when cs & rd & wr: no write and no read; err pulses.
- **Out of range**, when addr ≥ DEPTH and the command is a read or write:
  - A write is dropped and err pulses.
  - A read returns rdata=0 with rvalid=1 and err pulses, both in the same cycle as rvalid.

Clear FSM, states CLEAR and IDLE:
- An edge with rst=1 forces CLEAR when CLEAR_ON_RESET=1, otherwise IDLE. It also sets clr_addr=0.
- In CLEAR, each edge writes 0 to mem[clr_addr] and increments clr_addr. At clr_addr=DEPTH−1 the FSM moves to IDLE.
- busy=1 exactly while the state is CLEAR.
- Commands presented while busy=1 are dropped silently: no err, no rvalid.
- Reset during CLEAR restarts the clear at address 0.
- Reset during an in-flight read flushes it; no rvalid is produced.

Reset values after any edge with rst=1:
- rdata=0, rvalid=0, err=0.
- busy=CLEAR_ON_RESET.

## Timing
- **Write:** the new contents are visible to a read issued on the next edge.
- **Read, RD_LAT=1:** a read accepted at edge N puts rdata and rvalid in the cycle after edge N.
- **Read, RD_LAT=2:** the same read puts rdata and rvalid in the cycle after edge N+1. The internal stage is a registered copy of the array output.
- **Throughput:** one command per cycle. Back-to-back reads give back-to-back rvalid in issue order.
- **Read after write:** a write at N followed by a read of the same address at N+1 returns the new data.
- **Clear duration:** with CLEAR_ON_RESET=1, busy stays high for exactly DEPTH cycles after the first edge with rst=0. The first command can be accepted at edge DEPTH+1 counted from rst release.
- **err timing:**
  - Collision and write-out-of-range: err is registered one edge after the command, so it appears in the cycle after edge N.
  - Read-out-of-range: err follows the read pipeline and is aligned with rvalid.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset clear:** DEPTH=16, CLEAR_ON_RESET=1; pulse rst for 1 cycle, then read all 16 addresses. Required: busy=1 for exactly 16 cycles, every read returns 0, and rvalid is seen 16 times.
- **Byte enables:** DATA_W=32. Write 0xAABBCCDD with be=4'b1111 to addr 5, then write 0x11223344 with be=4'b0101 to addr 5, then read addr 5. Required: rdata=0xAA22CC44.
- **Latency and pipelining:** RD_LAT=2; write addr 0..3 with values 10..13, then read addr 0..3 back-to-back. Required: rvalid high for 4 consecutive cycles starting 2 cycles after the first read, with rdata sequence 10, 11, 12, 13.
- **Collision and range:** DEPTH=1000.
  - cs=rd=wr=1 at addr 7: err pulses, mem[7] is unchanged, no rvalid.
  - Read addr 1010: rvalid=1, rdata=0, err=1 in the same cycle.
  - Write addr 1010: err pulses and no word changes.
- **Reset mid-clear and mid-read:**
  - Assert rst at clear cycle 9: busy continues and the clear then takes a full DEPTH cycles.
  - Assert rst the cycle after a read is accepted with RD_LAT=2: no rvalid, and rdata=0.
- **Busy gating:** issue a write to addr 3 with value 0x5A during busy. Required: no err. After the clear completes, a read of addr 3 returns 0.
